// File: rtl/hc595_serializer_if.sv
// Frame handshake and 74HC595 pin bundle between the upstream encoder and the serializer.
interface hc595_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              done;
  logic              oe_595;
  logic              shcp_595;
  logic              stcp_595;
  logic              ds;

  modport master (
    output din, din_valid,
    input  din_ready, done, oe_595, shcp_595, stcp_595, ds
  );

  modport slave (
    input  din, din_valid,
    output din_ready, done, oe_595, shcp_595, stcp_595, ds
  );
endinterface

// File: rtl/hc595_serializer.sv
// Parallel-to-serial driver for a 74HC595 chain: takes one frame per handshake,
// clocks it out on ds/shcp_595, latches it with stcp_595 and enables the outputs
// only once the first complete frame has been latched.
module hc595_serializer #(
  parameter int DATA_W    = 16,
  parameter int CLK_DIV   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic   clk,
  input  logic   rst_n,
  hc595_if.slave bus
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  // Bit that goes out next for the configured shift direction.
  function automatic logic cur_bit(input logic [DATA_W-1:0] w);
    logic b;
    if (MSB_FIRST) begin
      b = w[DATA_W-1];
    end else begin
      b = w[0];
    end
    return b;
  endfunction

  // Word after one bit has been sent (written with shifts so DATA_W=1 stays legal).
  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    if (MSB_FIRST) begin
      r = w << 1;
    end else begin
      r = w >> 1;
    end
    return r;
  endfunction

  state_t            state_r, state_nx_s;
  logic [DIV_W-1:0]  div_r, div_nx_s;
  logic [BIT_W-1:0]  bit_r, bit_nx_s;
  logic [DATA_W-1:0] sh_r, sh_nx_s;
  logic              ds_r, ds_nx_s;
  logic              shcp_r, shcp_nx_s;
  logic              stcp_r, stcp_nx_s;
  logic              done_r, done_nx_s;
  logic              oe_r, oe_nx_s;

  logic              div_last_s;
  logic [BIT_W-1:0]  bit_inc_s;
  logic [DATA_W-1:0] sh_adv_s;

  assign div_last_s = (div_r == DIV_LAST);
  assign bit_inc_s  = bit_r + BIT_ONE;
  assign sh_adv_s   = advance(sh_r);

  assign bus.din_ready = (state_r == IDLE) && rst_n;
  assign bus.done      = done_r;
  assign bus.oe_595    = oe_r;
  assign bus.shcp_595  = shcp_r;
  assign bus.stcp_595  = stcp_r;
  assign bus.ds        = ds_r;

  // State and output registers; reset forces a blank, disabled chain and drops any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      div_r   <= '0;
      bit_r   <= '0;
      sh_r    <= '0;
      ds_r    <= 1'b0;
      shcp_r  <= 1'b0;
      stcp_r  <= 1'b0;
      done_r  <= 1'b0;
      oe_r    <= 1'b1;
    end else begin
      state_r <= state_nx_s;
      div_r   <= div_nx_s;
      bit_r   <= bit_nx_s;
      sh_r    <= sh_nx_s;
      ds_r    <= ds_nx_s;
      shcp_r  <= shcp_nx_s;
      stcp_r  <= stcp_nx_s;
      done_r  <= done_nx_s;
      oe_r    <= oe_nx_s;
    end
  end

  // Next-state and next-output logic; ds only moves when a SHIFT_LO phase begins.
  always_comb begin
    state_nx_s = state_r;
    div_nx_s   = div_r;
    bit_nx_s   = bit_r;
    sh_nx_s    = sh_r;
    ds_nx_s    = ds_r;
    shcp_nx_s  = shcp_r;
    stcp_nx_s  = stcp_r;
    done_nx_s  = 1'b0;
    oe_nx_s    = oe_r;

    case (state_r)
      IDLE: begin
        if (bus.din_valid) begin
          state_nx_s = SHIFT_LO;
          sh_nx_s    = bus.din;
          bit_nx_s   = '0;
          div_nx_s   = '0;
          ds_nx_s    = cur_bit(bus.din);
          shcp_nx_s  = 1'b0;
        end else begin
          div_nx_s   = '0;
        end
      end

      SHIFT_LO: begin
        if (div_last_s) begin
          state_nx_s = SHIFT_HI;
          div_nx_s   = '0;
          shcp_nx_s  = 1'b1;
        end else begin
          div_nx_s   = div_r + DIV_ONE;
        end
      end

      SHIFT_HI: begin
        if (div_last_s) begin
          div_nx_s  = '0;
          shcp_nx_s = 1'b0;
          sh_nx_s   = sh_adv_s;
          bit_nx_s  = bit_inc_s;
          if (bit_inc_s == BIT_LAST) begin
            state_nx_s = LATCH;
            stcp_nx_s  = 1'b1;
          end else begin
            state_nx_s = SHIFT_LO;
            ds_nx_s    = cur_bit(sh_adv_s);
          end
        end else begin
          div_nx_s = div_r + DIV_ONE;
        end
      end

      LATCH: begin
        if (div_last_s) begin
          state_nx_s = IDLE;
          div_nx_s   = '0;
          stcp_nx_s  = 1'b0;
          done_nx_s  = 1'b1;
          oe_nx_s    = 1'b0;
        end else begin
          div_nx_s   = div_r + DIV_ONE;
        end
      end

      default: begin
        state_nx_s = IDLE;
        div_nx_s   = '0;
        shcp_nx_s  = 1'b0;
        stcp_nx_s  = 1'b0;
      end
    endcase
  end

endmodule
